// File: rtl/hex_scan_ctrl.sv
// hex_scan_ctrl: time-multiplexes one shared 7-segment nibble decoder across
// DIGITS display positions.
//
// The scanner walks the positions in order. Each position gets a slot of DIV
// clocks, and the first BLANK clocks of every slot are dark so the previous
// digit's segments cannot ghost onto the next digit.
//
// Digit values are double-buffered. A load outside a frame boundary lands in
// the pending buffer. The displayed buffer only changes on a frame transfer, so
// a frame never mixes old and new digits. A load that coincides with the
// transfer itself bypasses the pending buffer and is shown straight away.
//
// All outputs come from flops. Their next values are decoded from the
// next-state signals, so each output changes on the same edge as the state
// that defines it.
module hex_scan_ctrl #(
  parameter int DIGITS = 4,
  parameter int DIV    = 1000,
  parameter int BLANK  = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                load_i,
  input  logic [4*DIGITS-1:0] digits_in_i,
  input  logic [DIGITS-1:0]   blank_mask_i,
  output logic [3:0]          hex_h_o,
  output logic [DIGITS-1:0]   an_o,
  output logic                frame_done_o,
  output logic                pend_valid_o
);

  // Counter widths: at least one bit each, so DIV=2 and DIGITS=1 still build.
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_C  = CW'(BLANK);
  localparam logic [IW-1:0] IDX_ZERO = IW'(0);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [IW-1:0] IDX_MAX  = IW'(DIGITS - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } state_e;

  // Scan sequencing state.
  state_e                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  // Double-buffered digit data.
  logic [4*DIGITS-1:0]   pending_q, pending_d;
  logic [DIGITS-1:0]     pend_mask_q, pend_mask_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [4*DIGITS-1:0]   active_q, active_d;
  logic [DIGITS-1:0]     act_mask_q, act_mask_d;

  // Output flops and their next values.
  logic [3:0]            hex_q, hex_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic                  frame_done_q, frame_done_d;

  // A frame transfer happens on this edge.
  logic                  xfer_s;
  // The next slot position is past its blanking window.
  logic                  lit_s;

  // Next-state logic for the scan sequencer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    xfer_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en_i) begin
          // Enabling starts a fresh frame, so it loads new digits as well.
          state_d = S_SCAN;
          idx_d   = IDX_ZERO;
          cnt_d   = CNT_ZERO;
          xfer_s  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SCAN: begin
        if (!en_i) begin
          state_d = S_IDLE;
          idx_d   = IDX_ZERO;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_MAX) begin
          cnt_d = CNT_ZERO;
          if (idx_q == IDX_MAX) begin
            // Last cycle of the frame: wrap to digit 0 and swap buffers.
            idx_d  = IDX_ZERO;
            xfer_s = 1'b1;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = IDX_ZERO;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Buffer update: a transfer takes either the bypassed load or the pending data.
  always_comb begin
    pending_d    = pending_q;
    pend_mask_d  = pend_mask_q;
    pend_valid_d = pend_valid_q;
    active_d     = active_q;
    act_mask_d   = act_mask_q;
    if (xfer_s) begin
      if (load_i) begin
        active_d   = digits_in_i;
        act_mask_d = blank_mask_i;
      end else if (pend_valid_q) begin
        active_d   = pending_q;
        act_mask_d = pend_mask_q;
      end else begin
        active_d   = active_q;
        act_mask_d = act_mask_q;
      end
      pend_valid_d = 1'b0;
    end else if (load_i) begin
      // A later load simply overwrites an earlier one.
      pending_d    = digits_in_i;
      pend_mask_d  = blank_mask_i;
      pend_valid_d = 1'b1;
    end else begin
      pend_valid_d = pend_valid_q;
    end
  end

  // With no blanking every slot cycle is lit, so no comparison is needed.
  generate
    if (BLANK == 0) begin : g_no_blank
      assign lit_s = 1'b1;
    end else begin : g_blank
      assign lit_s = (cnt_d >= BLANK_C);
    end
  endgenerate

  // Output decode from the next state so the output flops line up with the state.
  always_comb begin
    hex_d        = 4'h0;
    an_d         = '0;
    frame_done_d = 1'b0;
    if (state_d == S_SCAN) begin
      for (int k = 0; k < DIGITS; k++) begin
        if (idx_d == IW'(k)) begin
          hex_d   = active_d[4*k +: 4];
          an_d[k] = lit_s & ~act_mask_d[k];
        end else begin
          an_d[k] = 1'b0;
        end
      end
      frame_done_d = (cnt_d == CNT_MAX) && (idx_d == IDX_MAX);
    end else begin
      hex_d        = 4'h0;
      an_d         = '0;
      frame_done_d = 1'b0;
    end
  end

  // State, buffer and output registers with asynchronous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      idx_q        <= IDX_ZERO;
      cnt_q        <= CNT_ZERO;
      pending_q    <= '0;
      pend_mask_q  <= '0;
      pend_valid_q <= 1'b0;
      active_q     <= '0;
      act_mask_q   <= '0;
      hex_q        <= 4'h0;
      an_q         <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      pend_mask_q  <= pend_mask_d;
      pend_valid_q <= pend_valid_d;
      active_q     <= active_d;
      act_mask_q   <= act_mask_d;
      hex_q        <= hex_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign hex_h_o      = hex_q;
  assign an_o         = an_q;
  assign frame_done_o = frame_done_q;
  assign pend_valid_o = pend_valid_q;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Directed testbench for hex_scan_ctrl with DIGITS=4, DIV=8, BLANK=2.
// The variable p counts cycles since the scan started at enable edge E.
// It is the sample index taken #1 after edge E+p.
module tb_hex_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  blank_mask;
  logic [3:0]  hex_h;
  logic [3:0]  an;
  logic        frame_done;
  logic        pend_valid;

  int checks = 0;
  int errors = 0;
  int p = 0;

  hex_scan_ctrl #(.DIGITS(4), .DIV(8), .BLANK(2)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (en),
    .load_i       (load),
    .digits_in_i  (digits_in),
    .blank_mask_i (blank_mask),
    .hex_h_o      (hex_h),
    .an_o         (an),
    .frame_done_o (frame_done),
    .pend_valid_o (pend_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected nibble at scan position q for displayed value v.
  function automatic logic [3:0] exp_hex(int q, logic [15:0] v);
    int idx;
    idx = (q / 8) % 4;
    return v[idx*4 +: 4];
  endfunction

  // Expected digit enables at scan position q for mask m.
  function automatic logic [3:0] exp_an(int q, logic [3:0] m);
    int c;
    int idx;
    c   = q % 8;
    idx = (q / 8) % 4;
    if (c >= 2 && m[idx] == 1'b0) return 4'b0001 << idx;
    else return 4'b0000;
  endfunction

  // Expected frame_done at scan position q.
  function automatic logic exp_fd(int q);
    return ((q % 8) == 7) && (((q / 8) % 4) == 3);
  endfunction

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; load = 1'b0; digits_in = 16'h0000; blank_mask = 4'b0000;
    #2;
    checks++; if (an !== 4'b0000) begin errors++; $display("FAIL reset_an got %b exp 0000", an); end
    checks++; if (hex_h !== 4'h0) begin errors++; $display("FAIL reset_hex got %h exp 0", hex_h); end
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++; if (an !== 4'b0000) begin errors++; $display("FAIL idle_an i=%0d got %b exp 0000", i, an); end
      checks++; if (hex_h !== 4'h0) begin errors++; $display("FAIL idle_hex i=%0d got %h exp 0", i, hex_h); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL idle_fd i=%0d got %b exp 0", i, frame_done); end
      checks++; if (pend_valid !== 1'b0) begin errors++; $display("FAIL idle_pv i=%0d got %b exp 0", i, pend_valid); end
    end
  endtask

  task automatic test_basic_scan();
    load = 1'b1; digits_in = 16'h4321; blank_mask = 4'b0000;
    tick();
    checks++; if (pend_valid !== 1'b1) begin errors++; $display("FAIL idle_load_pv got %b exp 1", pend_valid); end
    checks++; if (an !== 4'b0000) begin errors++; $display("FAIL idle_load_an got %b exp 0000", an); end
    load = 1'b0; en = 1'b1; p = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      checks++; if (hex_h !== exp_hex(p, 16'h4321)) begin errors++; $display("FAIL basic_hex p=%0d got %h exp %h", p, hex_h, exp_hex(p, 16'h4321)); end
      checks++; if (an !== exp_an(p, 4'b0000)) begin errors++; $display("FAIL basic_an p=%0d got %b exp %b", p, an, exp_an(p, 4'b0000)); end
      checks++; if (frame_done !== exp_fd(p)) begin errors++; $display("FAIL basic_fd p=%0d got %b exp %b", p, frame_done, exp_fd(p)); end
      checks++; if (pend_valid !== 1'b0) begin errors++; $display("FAIL basic_pv p=%0d got %b exp 0", p, pend_valid); end
      p++;
    end
  endtask

  task automatic test_double_buffer();
    logic [15:0] v;
    logic        pv;
    for (int i = 0; i < 64; i++) begin
      tick();
      v  = (p < 96) ? 16'h4321 : 16'hABCD;
      pv = (p >= 74) && (p < 96);
      checks++; if (hex_h !== exp_hex(p, v)) begin errors++; $display("FAIL dbuf_hex p=%0d got %h exp %h", p, hex_h, exp_hex(p, v)); end
      checks++; if (an !== exp_an(p, 4'b0000)) begin errors++; $display("FAIL dbuf_an p=%0d got %b exp %b", p, an, exp_an(p, 4'b0000)); end
      checks++; if (frame_done !== exp_fd(p)) begin errors++; $display("FAIL dbuf_fd p=%0d got %b exp %b", p, frame_done, exp_fd(p)); end
      checks++; if (pend_valid !== pv) begin errors++; $display("FAIL dbuf_pv p=%0d got %b exp %b", p, pend_valid, pv); end
      load = (p == 73); digits_in = 16'hABCD; blank_mask = 4'b0000;
      p++;
    end
  endtask

  task automatic test_bypass_last_wins();
    logic [15:0] v;
    logic        pv;
    for (int i = 0; i < 64; i++) begin
      tick();
      v  = (p < 160) ? 16'hABCD : 16'h3333;
      pv = (p >= 131) && (p < 160);
      checks++; if (hex_h !== exp_hex(p, v)) begin errors++; $display("FAIL byp_hex p=%0d got %h exp %h", p, hex_h, exp_hex(p, v)); end
      checks++; if (an !== exp_an(p, 4'b0000)) begin errors++; $display("FAIL byp_an p=%0d got %b exp %b", p, an, exp_an(p, 4'b0000)); end
      checks++; if (frame_done !== exp_fd(p)) begin errors++; $display("FAIL byp_fd p=%0d got %b exp %b", p, frame_done, exp_fd(p)); end
      checks++; if (pend_valid !== pv) begin errors++; $display("FAIL byp_pv p=%0d got %b exp %b", p, pend_valid, pv); end
      blank_mask = 4'b0000;
      if (p == 130) begin load = 1'b1; digits_in = 16'h1111; end
      else if (p == 139) begin load = 1'b1; digits_in = 16'h2222; end
      else if (p == 159) begin load = 1'b1; digits_in = 16'h3333; end
      else load = 1'b0;
      p++;
    end
  endtask

  task automatic test_mask();
    logic [15:0] v;
    logic [3:0]  m;
    logic        pv;
    for (int i = 0; i < 64; i++) begin
      tick();
      v  = (p < 224) ? 16'h3333 : 16'h5678;
      m  = (p < 224) ? 4'b0000 : 4'b1000;
      pv = (p >= 194) && (p < 224);
      checks++; if (hex_h !== exp_hex(p, v)) begin errors++; $display("FAIL mask_hex p=%0d got %h exp %h", p, hex_h, exp_hex(p, v)); end
      checks++; if (an !== exp_an(p, m)) begin errors++; $display("FAIL mask_an p=%0d got %b exp %b", p, an, exp_an(p, m)); end
      checks++; if (frame_done !== exp_fd(p)) begin errors++; $display("FAIL mask_fd p=%0d got %b exp %b", p, frame_done, exp_fd(p)); end
      checks++; if (pend_valid !== pv) begin errors++; $display("FAIL mask_pv p=%0d got %b exp %b", p, pend_valid, pv); end
      if (p == 193) begin load = 1'b1; digits_in = 16'h9999; blank_mask = 4'b0000; end
      else if (p == 195) begin load = 1'b1; digits_in = 16'h5678; blank_mask = 4'b1000; end
      else load = 1'b0;
      p++;
    end
  endtask

  task automatic test_disable();
    // Scan into digit 2 (p=275 is idx 2, cnt 3, lit), then drop en.
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++; if (hex_h !== exp_hex(p, 16'h5678)) begin errors++; $display("FAIL dis_hex p=%0d got %h exp %h", p, hex_h, exp_hex(p, 16'h5678)); end
      checks++; if (an !== exp_an(p, 4'b1000)) begin errors++; $display("FAIL dis_an p=%0d got %b exp %b", p, an, exp_an(p, 4'b1000)); end
      en = (p != 275);
      p++;
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (an !== 4'b0000) begin errors++; $display("FAIL off_an i=%0d got %b exp 0000", i, an); end
      checks++; if (hex_h !== 4'h0) begin errors++; $display("FAIL off_hex i=%0d got %h exp 0", i, hex_h); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL off_fd i=%0d got %b exp 0", i, frame_done); end
    end
    en = 1'b1; p = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (hex_h !== exp_hex(p, 16'h5678)) begin errors++; $display("FAIL reen_hex p=%0d got %h exp %h", p, hex_h, exp_hex(p, 16'h5678)); end
      checks++; if (an !== exp_an(p, 4'b1000)) begin errors++; $display("FAIL reen_an p=%0d got %b exp %b", p, an, exp_an(p, 4'b1000)); end
      p++;
    end
  endtask

  task automatic test_async_reset();
    // Sampled #1 after the edge at p=4: digit 0 is lit.
    #2;
    rst = 1'b1;
    #1;
    checks++; if (an !== 4'b0000) begin errors++; $display("FAIL arst_an got %b exp 0000", an); end
    checks++; if (hex_h !== 4'h0) begin errors++; $display("FAIL arst_hex got %h exp 0", hex_h); end
    checks++; if (pend_valid !== 1'b0) begin errors++; $display("FAIL arst_pv got %b exp 0", pend_valid); end
    en = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++; if (an !== 4'b0000) begin errors++; $display("FAIL post_rst_an got %b exp 0000", an); end
    // Restart: the displayed buffer was cleared, so every nibble is 0.
    en = 1'b1; p = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++; if (hex_h !== 4'h0) begin errors++; $display("FAIL rst_scan_hex p=%0d got %h exp 0", p, hex_h); end
      checks++; if (an !== exp_an(p, 4'b0000)) begin errors++; $display("FAIL rst_scan_an p=%0d got %b exp %b", p, an, exp_an(p, 4'b0000)); end
      p++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_double_buffer();
    test_bypass_last_wins();
    test_mask();
    test_disable();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_scan_ctrl.md
# hex_scan_ctrl

Time-multiplexing scheduler that shares one `hex` 7-segment decoder between `DIGITS` display positions. Holds a double-buffered set of digit nibbles, presents one nibble per slot to the shared decoder and drives the matching digit-enable line. Inserts blanking cycles at each slot start to prevent ghosting. Sits between the state/counter logic that produces digit values and the board display, replacing one `hex` instance per digit.

## Interface
Parameters:
- `DIGITS`, 4, number of multiplexed digit positions (>= 1)
- `DIV`, 1000, clock cycles per digit slot (>= 2)
- `BLANK`, 2, blanking cycles at the start of each slot (0 <= BLANK < DIV)

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  reset; asynchronous, active-high
- `en`  in  1  scan enable; 0 = display dark, scanner idle
- `load`  in  1  capture `digits_in`/`blank_mask` into the pending buffer this cycle
- `digits_in`  in  4*DIGITS  digit nibbles; digit k = bits [4k+3:4k]
- `blank_mask`  in  DIGITS  1 = digit k suppressed (never enabled)
- `hex_h`  out  4  nibble to the shared `hex` decoder `.h` input
- `an`  out  DIGITS  one-hot-or-zero digit enable, active-high
- `frame_done`  out  1  one-cycle pulse on the last cycle of each frame
- `pend_valid`  out  1  pending buffer holds data not yet shown

## Operation
- Registers: `pending`/`pend_mask` (load buffer), `active`/`act_mask` (displayed), `idx` (0..DIGITS-1), `cnt` (0..DIV-1, width $clog2(DIV), min 1), `state` in {IDLE, SCAN}, `pend_valid`.
- All outputs are decoded from registers only; there is no combinational path from inputs to outputs.
- Reset: state=IDLE, idx=0, cnt=0, pending=active=0, masks=0, pend_valid=0. Outputs: hex_h=0, an=0, frame_done=0, pend_valid=0.
- IDLE: an=0, hex_h=0, frame_done=0. If `en`=1, go to SCAN with idx=0, cnt=0, and perform a frame transfer.
- SCAN, every cycle:
  - hex_h = active nibble [idx].
  - an[idx] = 1 iff cnt >= BLANK and act_mask[idx]=0. All other bits are 0.
  - cnt increments. When cnt=DIV-1: cnt wraps to 0 and idx increments, wrapping DIGITS-1 -> 0.
  - frame_done = 1 iff cnt=DIV-1 and idx=DIGITS-1.
  - When idx=DIGITS-1 and cnt=DIV-1, perform a frame transfer on that edge.
- SCAN with `en`=0 sampled: go to IDLE next cycle, idx=0, cnt=0. `active` is kept.
- Frame transfer:
  - If `load`=1 that cycle: active<=digits_in, act_mask<=blank_mask.
  - Otherwise, if pend_valid=1: active<=pending, act_mask<=pend_mask.
  - pend_valid<=0.
  - Without a pending load, `active` is unchanged.
- `load` outside a transfer cycle: pending<=digits_in, pend_mask<=blank_mask, pend_valid<=1. A later load overwrites earlier pending data (last wins).
- `load` on a transfer cycle bypasses to `active` and leaves pend_valid=0.
- `active` never changes mid-frame, so there is no tearing.
- `load` is honoured in IDLE as well.

## Timing
- Frame length: DIGITS*DIV cycles. Each slot has BLANK dark cycles, then DIV-BLANK lit cycles.
- After `en` rises (sampled 1 at edge E, state IDLE): SCAN starts at E.
  - an[0] rises at edge E+BLANK, unless digit 0 is masked.
  - With BLANK=0 it rises at E.
- After `en` falls (sampled 0 at edge F): an=0 from edge F.
- Latency from `load` to display: the value appears at the next frame boundary.
  - Worst case: DIGITS*DIV cycles.
  - The bypass on a transfer cycle gives the new value at the very next edge.
- `rst` asserted mid-scan: all registers clear immediately and asynchronously, an=0 at once. The scanner restarts from IDLE after release.
- Digit enables never overlap. Between consecutive lit digits there are exactly BLANK dark cycles.

## Test plan
All scenarios use DIGITS=4, DIV=8, BLANK=2.

- **Reset/idle:** rst pulse, en=0 for 20 cycles -> an=0, hex_h=0, frame_done=0, pend_valid=0 throughout.
- **Basic scan:** load 16'h4321 with mask 0 (in IDLE), then en=1 -> hex_h steps 1,2,3,4 every 8 cycles. an follows 0000 x2, 0001 x6, 0000 x2, 0010 x6, and so on. frame_done pulses every 32 cycles on idx=3, cnt=7.
- **Double buffer:** while scanning digit 1, load 16'hABCD -> pend_valid=1. The current frame continues to show 1,2,3,4. The next frame shows D,C,B,A and pend_valid=0 after the boundary.
- **Bypass and last-wins:** load 16'h1111 and then 16'h2222 mid-frame, and load 16'h3333 on the frame_done cycle -> the next frame shows all 3s and pend_valid=0.
- **Mask:** blank_mask=4'b1000 loaded -> an[3] is never asserted. hex_h still shows digit 3 during its slot, and frame timing is unchanged.
- **Disable/async reset:** drop en during digit 2 -> an=0 from the next edge. Re-enable -> restarts at digit 0, with the first lit cycle 2 cycles later. Assert rst mid-lit slot -> an=0 with no clock edge.
